// File: rtl/gbt_link_monitor_pkg.sv
// Shared definitions for the GBT link monitor: state encoding and default sizing.
package gbt_link_monitor_pkg;

  typedef enum logic [1:0] {
    ST_DOWN = 2'd0,
    ST_QUAL = 2'd1,
    ST_UP   = 2'd2,
    ST_LOST = 2'd3
  } link_state_t;

  localparam int DEF_QUAL_CYCLES   = 4096;
  localparam int DEF_GLITCH_CYCLES = 8;
  localparam int DEF_CNT_BITS      = 16;

endpackage

// File: rtl/gbt_link_monitor_sync_2ff.sv
// Two-flop synchroniser for asynchronous level signals, async active-low reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/gbt_link_monitor.sv
// Qualifies the GBT link for the reset generator: sustained-good window before ready,
// short rxvalid dropouts tolerated, saturating drop/error counters for slow control.
module gbt_link_monitor
  import gbt_link_monitor_pkg::*;
#(
  parameter int QUAL_CYCLES   = DEF_QUAL_CYCLES,
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
  parameter int CNT_BITS      = DEF_CNT_BITS
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                gbt_rxready_i,
  input  logic                gbt_txready_i,
  input  logic                gbt_rxvalid_i,
  input  logic                gbt_frame_err_i,
  input  logic                cnt_reset_i,
  output logic                link_ready_o,
  output logic                link_up_pulse_o,
  output logic [1:0]          link_state_o,
  output logic [CNT_BITS-1:0] unlock_cnt_o,
  output logic [CNT_BITS-1:0] err_cnt_o
);

  localparam int QW = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;
  localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [QW-1:0] QUAL_LOAD   = QW'(QUAL_CYCLES - 1);
  localparam logic [GW-1:0] GLITCH_LOAD = GW'(GLITCH_CYCLES - 1);

  logic [1:0]          w_sync;
  logic                w_rdy;
  logic                w_ok;
  logic                w_drop;
  link_state_t         r_state;
  logic [QW-1:0]       r_qual_cnt;
  logic [GW-1:0]       r_glitch_cnt;
  logic                r_up_pulse;
  logic [CNT_BITS-1:0] r_unlock_cnt;
  logic [CNT_BITS-1:0] r_err_cnt;

  sync_2ff #(.WIDTH(2)) u_sync (
    .i_clk   (clock_i),
    .i_rst_n (reset_n_i),
    .i_d     ({gbt_rxready_i, gbt_txready_i}),
    .o_q     (w_sync)
  );

  assign w_rdy = &w_sync;
  assign w_ok  = w_rdy & gbt_rxvalid_i;

  // Loss of a qualified link only; aborting qualification is not an unlock.
  assign w_drop = ((r_state == ST_UP) && !w_rdy) ||
                  ((r_state == ST_LOST) &&
                   (!w_rdy || (!gbt_rxvalid_i && (r_glitch_cnt == '0))));

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_DOWN;
      r_qual_cnt   <= '0;
      r_glitch_cnt <= '0;
      r_up_pulse   <= 1'b0;
    end else begin
      r_up_pulse <= 1'b0;
      case (r_state)
        ST_DOWN: begin
          if (w_ok) begin
            r_state    <= ST_QUAL;
            r_qual_cnt <= QUAL_LOAD;
          end
        end
        ST_QUAL: begin
          if (!w_ok) begin
            r_state <= ST_DOWN;
          end else if (r_qual_cnt == '0) begin
            r_state    <= ST_UP;
            r_up_pulse <= 1'b1;
          end else begin
            r_qual_cnt <= r_qual_cnt - 1'b1;
          end
        end
        ST_UP: begin
          if (!w_rdy) begin
            r_state <= ST_DOWN;
          end else if (!gbt_rxvalid_i) begin
            r_state      <= ST_LOST;
            r_glitch_cnt <= GLITCH_LOAD;
          end
        end
        ST_LOST: begin
          if (!w_rdy) begin
            r_state <= ST_DOWN;
          end else if (gbt_rxvalid_i) begin
            r_state <= ST_UP;
          end else if (r_glitch_cnt == '0) begin
            r_state <= ST_DOWN;
          end else begin
            r_glitch_cnt <= r_glitch_cnt - 1'b1;
          end
        end
        default: r_state <= ST_DOWN;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_unlock_cnt <= '0;
      r_err_cnt    <= '0;
    end else if (cnt_reset_i) begin
      r_unlock_cnt <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (w_drop && (r_unlock_cnt != '1)) begin
        r_unlock_cnt <= r_unlock_cnt + 1'b1;
      end
      if (r_state[1] && gbt_frame_err_i && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign link_ready_o    = r_state[1];
  assign link_state_o    = r_state;
  assign link_up_pulse_o = r_up_pulse;
  assign unlock_cnt_o    = r_unlock_cnt;
  assign err_cnt_o       = r_err_cnt;

endmodule

// File: tb/tb_gbt_link_monitor.sv
// Bench for gbt_link_monitor: fixed vector table, run-length reference model under
// random stimulus, and directed saturation / clear / async-reset sequences.
module tb_gbt_link_monitor;

  localparam int QUAL   = 4;
  localparam int GLITCH = 3;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rx, tx, v, fe, cr;
  logic          link_ready_o, link_up_pulse_o;
  logic [1:0]    link_state_o;
  logic [CW-1:0] unlock_cnt_o, err_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  gbt_link_monitor #(.QUAL_CYCLES(QUAL), .GLITCH_CYCLES(GLITCH), .CNT_BITS(CW)) dut (
    .clock_i         (clk),
    .reset_n_i       (reset_n),
    .gbt_rxready_i   (rx),
    .gbt_txready_i   (tx),
    .gbt_rxvalid_i   (v),
    .gbt_frame_err_i (fe),
    .cnt_reset_i     (cr),
    .link_ready_o    (link_ready_o),
    .link_up_pulse_o (link_up_pulse_o),
    .link_state_o    (link_state_o),
    .unlock_cnt_o    (unlock_cnt_o),
    .err_cnt_o       (err_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: link is up after QUAL+1 consecutive ok samples; once up it
  // drops on !rdy or on a run of more than GLITCH low rxvalid samples.
  bit m_rx1, m_rx2, m_tx1, m_tx2;
  bit m_up, m_pulse;
  int m_okrun, m_lowrun, m_unl, m_err;

  function automatic void model_reset();
    m_rx1 = 0; m_rx2 = 0; m_tx1 = 0; m_tx2 = 0;
    m_up = 0; m_pulse = 0; m_okrun = 0; m_lowrun = 0; m_unl = 0; m_err = 0;
  endfunction

  function automatic void model_edge();
    bit rdy, ok, was_up, drop;
    rdy = m_rx2 & m_tx2;
    ok = rdy & v;
    was_up = m_up;
    drop = 0;
    m_pulse = 0;
    if (m_up) begin
      if (!rdy) drop = 1;
      else if (v) m_lowrun = 0;
      else begin
        m_lowrun++;
        if (m_lowrun > GLITCH) drop = 1;
      end
      if (drop) begin m_up = 0; m_lowrun = 0; m_okrun = 0; end
    end else if (ok) begin
      m_okrun++;
      if (m_okrun == QUAL + 1) begin m_up = 1; m_pulse = 1; m_okrun = 0; end
    end else begin
      m_okrun = 0;
    end
    if (cr) begin
      m_unl = 0; m_err = 0;
    end else begin
      if (drop && m_unl < CMAX) m_unl++;
      if (was_up && fe && m_err < CMAX) m_err++;
    end
    m_rx2 = m_rx1; m_rx1 = rx;
    m_tx2 = m_tx1; m_tx1 = tx;
  endfunction

  function automatic int model_state();
    if (m_up) return (m_lowrun > 0) ? 3 : 2;
    return (m_okrun > 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_state", link_state_o, model_state());
    check("model_ready", link_ready_o, m_up);
    check("model_pulse", link_up_pulse_o, m_pulse);
    check("model_unlock", unlock_cnt_o, m_unl);
    check("model_err", err_cnt_o, m_err);
  endtask

  task automatic bring_up();
    for (int i = 0; i < 30 && !m_up; i++) step();
    check("bring_up_reached", link_ready_o, 1);
  endtask

  task automatic async_reset(input string tag);
    #3 reset_n = 1'b0;
    #2;
    check({tag, "_rst_ready"}, link_ready_o, 0);
    check({tag, "_rst_state"}, link_state_o, 0);
    check({tag, "_rst_pulse"}, link_up_pulse_o, 0);
    check({tag, "_rst_unlock"}, unlock_cnt_o, 0);
    check({tag, "_rst_err"}, err_cnt_o, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic count_to_ready(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (link_ready_o === 1'b1) break;
    end
    check({tag, "_requal_latency"}, n, QUAL + 3);
  endtask

  typedef struct {
    logic       rx, tx, v, fe, cr;
    logic [1:0] st;
    logic       rdy, p;
    logic [3:0] unl, err;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input int r, t, vv, f, c, st, rd, p, u, e);
    vec_t x;
    x.rx = 1'(r); x.tx = 1'(t); x.v = 1'(vv); x.fe = 1'(f); x.cr = 1'(c);
    x.st = 2'(st); x.rdy = 1'(rd); x.p = 1'(p); x.unl = 4'(u); x.err = 4'(e);
    return x;
  endfunction

  initial begin
    // Edge-by-edge from reset release: bring-up, glitch tolerance, glitch drop,
    // qualification abort and full restart, rxready loss, counter clear.
    tbl[0]  = mk(1,1,1,0,0, 0,0,0,0,0);
    tbl[1]  = mk(1,1,1,0,0, 0,0,0,0,0);
    tbl[2]  = mk(1,1,1,0,0, 1,0,0,0,0);
    tbl[3]  = mk(1,1,1,0,0, 1,0,0,0,0);
    tbl[4]  = mk(1,1,1,1,0, 1,0,0,0,0);
    tbl[5]  = mk(1,1,1,0,0, 1,0,0,0,0);
    tbl[6]  = mk(1,1,1,0,0, 2,1,1,0,0);
    tbl[7]  = mk(1,1,1,0,0, 2,1,0,0,0);
    tbl[8]  = mk(1,1,0,0,0, 3,1,0,0,0);
    tbl[9]  = mk(1,1,0,0,0, 3,1,0,0,0);
    tbl[10] = mk(1,1,0,0,0, 3,1,0,0,0);
    tbl[11] = mk(1,1,1,0,0, 2,1,0,0,0);
    tbl[12] = mk(1,1,1,1,0, 2,1,0,0,1);
    tbl[13] = mk(1,1,0,0,0, 3,1,0,0,1);
    tbl[14] = mk(1,1,0,0,0, 3,1,0,0,1);
    tbl[15] = mk(1,1,0,0,0, 3,1,0,0,1);
    tbl[16] = mk(1,1,0,0,0, 0,0,0,1,1);
    tbl[17] = mk(1,1,1,1,0, 1,0,0,1,1);
    tbl[18] = mk(1,1,1,0,0, 1,0,0,1,1);
    tbl[19] = mk(1,1,1,0,0, 1,0,0,1,1);
    tbl[20] = mk(1,1,0,0,0, 0,0,0,1,1);
    tbl[21] = mk(1,1,1,0,0, 1,0,0,1,1);
    tbl[22] = mk(1,1,1,0,0, 1,0,0,1,1);
    tbl[23] = mk(1,1,1,0,0, 1,0,0,1,1);
    tbl[24] = mk(1,1,1,0,0, 1,0,0,1,1);
    tbl[25] = mk(1,1,1,0,0, 2,1,1,1,1);
    tbl[26] = mk(0,1,1,0,0, 2,1,0,1,1);
    tbl[27] = mk(0,1,1,0,0, 2,1,0,1,1);
    tbl[28] = mk(0,1,1,0,0, 0,0,0,2,1);
    tbl[29] = mk(0,1,1,0,1, 0,0,0,0,0);

    reset_n = 1'b0;
    rx = 0; tx = 1; v = 1; fe = 0; cr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", link_state_o, 0);
    check("reset_ready", link_ready_o, 0);
    check("reset_pulse", link_up_pulse_o, 0);
    check("reset_unlock", unlock_cnt_o, 0);
    check("reset_err", err_cnt_o, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      rx = tbl[i].rx; tx = tbl[i].tx; v = tbl[i].v; fe = tbl[i].fe; cr = tbl[i].cr;
      step();
      check($sformatf("tbl%0d_state", i), link_state_o, tbl[i].st);
      check($sformatf("tbl%0d_ready", i), link_ready_o, tbl[i].rdy);
      check($sformatf("tbl%0d_pulse", i), link_up_pulse_o, tbl[i].p);
      check($sformatf("tbl%0d_unlock", i), unlock_cnt_o, tbl[i].unl);
      check($sformatf("tbl%0d_err", i), err_cnt_o, tbl[i].err);
    end

    for (int i = 0; i < 3000; i++) begin
      rx = ($urandom_range(0, 99) < 96);
      tx = ($urandom_range(0, 99) < 98);
      v  = ($urandom_range(0, 99) < 82);
      fe = ($urandom_range(0, 99) < 10);
      cr = ($urandom_range(0, 99) < 2);
      step();
    end

    rx = 1; tx = 1; v = 1; fe = 0; cr = 1;
    step();
    cr = 0;
    for (int d = 0; d < 20; d++) begin
      v = 1;
      bring_up();
      v = 0;
      repeat (GLITCH + 1) step();
    end
    check("unlock_saturated", unlock_cnt_o, CMAX);

    v = 1;
    bring_up();
    fe = 1;
    repeat (18) step();
    fe = 0;
    check("err_saturated", err_cnt_o, CMAX);

    async_reset("up");
    count_to_ready("up");

    v = 0;
    repeat (GLITCH + 1) step();
    v = 1;
    repeat (2) step();
    check("mid_qual_state", link_state_o, 1);
    async_reset("qual");
    count_to_ready("qual");

    fe = 1;
    step();
    fe = 0; v = 0;
    repeat (GLITCH + 1) step();
    v = 1;
    bring_up();
    check("pre_clear_unlock", unlock_cnt_o, 1);
    fe = 1; cr = 1;
    step();
    fe = 0; cr = 0;
    check("clear_unlock", unlock_cnt_o, 0);
    check("clear_err_wins", err_cnt_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
